// File: rtl/lcd_panel_sequencer.sv
// rtl/lcd_panel_sequencer.sv - RGB LCD power-up/power-down sequencer with frame-aligned video gating and VSYNC watchdog
module lcd_panel_sequencer #(
  parameter int PWR_CYCLES    = 90000,
  parameter int BLANK_FRAMES  = 2,
  parameter int OFF_FRAMES    = 2,
  parameter int FRAME_TIMEOUT = 400000,
  parameter int CNT_W         = 20
) (
  input  logic       PixelClk,
  input  logic       nRST,
  input  logic       Enable_Req,
  input  logic       LCD_VSYNC_In,
  output logic       Timing_En,
  output logic       LCD_DISP,
  output logic       Video_Mute,
  output logic       Seq_Busy,
  output logic [2:0] Seq_State,
  output logic       Fault
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_PWR_WAIT  = 3'd1,
    S_SYNC_WAIT = 3'd2,
    S_BLANK     = 3'd3,
    S_ON        = 3'd4,
    S_DRAIN     = 3'd5,
    S_PWR_DOWN  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(FRAME_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_FRAMES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_FRAMES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             fault_q, fault_d;
  logic             prev_vs_q, prev_vs_d;
  logic             fe_q, fe_d;
  logic             te_q, te_d, disp_q, disp_d, mute_q, mute_d, busy_q, busy_d;
  logic [2:0]       state_out_q, state_out_d;
  logic             fault_out_q, fault_out_d;
  logic             watched, wd_expired, pending_off;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign watched     = (state_q == S_SYNC_WAIT) || (state_q == S_BLANK) ||
                       (state_q == S_ON) || (state_q == S_DRAIN);
  assign wd_expired  = watched && (wd_cnt_q == WD_LAST);
  // Off request in ON is only acted on at a frame edge; a request that goes away first is forgotten
  assign pending_off = ~Enable_Req;

  // Frame edge detect: VSYNC 1->0, registered so fe lags the input fall by one cycle
  always_comb begin
    prev_vs_d = LCD_VSYNC_In;
    fe_d      = prev_vs_q & ~LCD_VSYNC_In;
  end

  // Next-state, counters and fault; watchdog beats abort, abort beats frame advance
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    fault_d     = fault_q;
    wd_cnt_d    = (!watched || fe_q) ? '0 : sat_inc(wd_cnt_q);
    if (wd_expired) begin
      fault_d  = 1'b1;
      wd_cnt_d = '0;
      cnt_d    = '0;
      if (state_q == S_SYNC_WAIT) state_d = S_OFF;
      else                        state_d = S_PWR_DOWN;
    end else begin
      case (state_q)
        S_OFF: begin
          if (!Enable_Req) fault_d = 1'b0;
          if (Enable_Req && !fault_q) begin
            state_d = S_PWR_WAIT;
            cnt_d   = '0;
          end
        end
        S_PWR_WAIT: begin
          if (!Enable_Req)            state_d = S_OFF;
          else if (cnt_q == PWR_LAST) state_d = S_SYNC_WAIT;
          else                        cnt_d   = sat_inc(cnt_q);
        end
        S_SYNC_WAIT: begin
          if (!Enable_Req) begin
            state_d = S_OFF;
          end else if (fe_q) begin
            state_d     = S_BLANK;
            frame_cnt_d = '0;
          end
        end
        S_BLANK: begin
          if (!Enable_Req) begin
            state_d     = S_DRAIN;
            frame_cnt_d = '0;
          end else if (fe_q) begin
            if (frame_cnt_q == BLANK_LAST) state_d     = S_ON;
            else                           frame_cnt_d = sat_inc(frame_cnt_q);
          end
        end
        S_ON: begin
          if (fe_q && pending_off) begin
            state_d     = S_DRAIN;
            frame_cnt_d = '0;
          end
        end
        S_DRAIN: begin
          if (fe_q) begin
            if (frame_cnt_q == OFF_LAST) begin
              state_d = S_PWR_DOWN;
              cnt_d   = '0;
            end else begin
              frame_cnt_d = sat_inc(frame_cnt_q);
            end
          end
        end
        S_PWR_DOWN: begin
          if (cnt_q == PWR_LAST) state_d = S_OFF;
          else                   cnt_d   = sat_inc(cnt_q);
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Moore output decode; the unused code 7 looks like OFF
  always_comb begin
    te_d        = 1'b0;
    disp_d      = 1'b0;
    mute_d      = 1'b1;
    busy_d      = 1'b0;
    state_out_d = state_q;
    fault_out_d = fault_q;
    case (state_q)
      S_PWR_WAIT, S_SYNC_WAIT, S_PWR_DOWN: begin
        te_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_BLANK, S_DRAIN: begin
        te_d   = 1'b1;
        disp_d = 1'b1;
        busy_d = 1'b1;
      end
      S_ON: begin
        te_d   = 1'b1;
        disp_d = 1'b1;
        mute_d = 1'b0;
      end
      default: ;
    endcase
  end

  // All state and output registers; reset drops the panel pins immediately
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      wd_cnt_q    <= '0;
      fault_q     <= 1'b0;
      prev_vs_q   <= 1'b1;
      fe_q        <= 1'b0;
      te_q        <= 1'b0;
      disp_q      <= 1'b0;
      mute_q      <= 1'b1;
      busy_q      <= 1'b0;
      state_out_q <= 3'd0;
      fault_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      fault_q     <= fault_d;
      prev_vs_q   <= prev_vs_d;
      fe_q        <= fe_d;
      te_q        <= te_d;
      disp_q      <= disp_d;
      mute_q      <= mute_d;
      busy_q      <= busy_d;
      state_out_q <= state_out_d;
      fault_out_q <= fault_out_d;
    end
  end

  assign Timing_En  = te_q;
  assign LCD_DISP   = disp_q;
  assign Video_Mute = mute_q;
  assign Seq_Busy   = busy_q;
  assign Seq_State  = state_out_q;
  assign Fault      = fault_out_q;

endmodule
